// File: rtl/add_num_pkg.sv
// Shared constants, operand/lane types and FSM state encoding for the
// add-two-numbers AFU read-path unpack stage.
package add_num_pkg;

  localparam int N_PAIRS = 32;
  localparam int OPND_W  = 8;
  localparam int LANE_W  = 16;

  typedef logic [OPND_W-1:0] t_opnd;
  typedef logic [LANE_W-1:0] t_lane;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RSP = 2'd1,
    COMPUTE  = 2'd2,
    OUTPUT   = 2'd3
  } t_unpack_state;

endpackage

// File: rtl/add_num_lane_adder.sv
// Combinational 8-bit pair adder producing one 16-bit result lane and an
// overflow bit. Macro ADD_NUM_UNPACK_SATURATE_EN clamps the lane to 255.
module add_num_lane_adder
  import add_num_pkg::*;
(
  input  t_opnd i_a,
  input  t_opnd i_b,
  output t_lane o_lane,
  output logic  o_ovf
);

  logic [OPND_W:0] w_sum;

  assign w_sum = {1'b0, i_a} + {1'b0, i_b};
  assign o_ovf = w_sum[OPND_W];

`ifdef ADD_NUM_UNPACK_SATURATE_EN
  assign o_lane = {{(LANE_W-OPND_W){1'b0}},
                   (w_sum[OPND_W] ? {OPND_W{1'b1}} : w_sum[OPND_W-1:0])};
`else
  assign o_lane = {{(LANE_W-OPND_W-1){1'b0}}, w_sum};
`endif

endmodule

// File: rtl/add_num_operand_unpack.sv
// Captures the c0 read-response line matching the armed mdata tag, sums its
// 32 operand pairs LANES_PER_CYCLE at a time and hands the packed result to
// the write stage. Optional macro: ADD_NUM_UNPACK_SATURATE_EN (lane clamp).
module add_num_operand_unpack
  import add_num_pkg::*;
#(
  parameter int LANES_PER_CYCLE = 4,
  parameter int MDATA_W         = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [MDATA_W-1:0]         exp_mdata,
  input  logic                       rsp_valid,
  input  logic [MDATA_W-1:0]         rsp_mdata,
  input  logic [N_PAIRS*LANE_W-1:0]  rsp_data,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [N_PAIRS*LANE_W-1:0]  res_data,
  output logic [N_PAIRS-1:0]         res_ovf,
  output logic                       busy,
  output logic                       err_tag
);

  localparam logic [5:0] CNT_STEP = 6'(LANES_PER_CYCLE);
  localparam logic [5:0] LAST_CNT = 6'(N_PAIRS - LANES_PER_CYCLE);

  t_unpack_state              r_state;
  logic [MDATA_W-1:0]         r_exp_mdata;
  logic [N_PAIRS*LANE_W-1:0]  r_line;
  logic [5:0]                 r_cnt;
  logic [N_PAIRS*LANE_W-1:0]  r_res_data;
  logic [N_PAIRS-1:0]         r_res_ovf;
  logic                       r_res_valid;
  logic                       r_busy;
  logic                       r_err_tag;

  t_opnd                      w_a [N_PAIRS];
  t_opnd                      w_b [N_PAIRS];
  t_lane                      w_lane [LANES_PER_CYCLE];
  logic                       w_ovf  [LANES_PER_CYCLE];
  logic [N_PAIRS*LANE_W-1:0]  w_res_data_next;
  logic [N_PAIRS-1:0]         w_res_ovf_next;
  logic                       w_tag_match;

  assign w_tag_match = (rsp_mdata == r_exp_mdata);

  genvar gi;
  generate
    for (gi = 0; gi < N_PAIRS; gi++) begin : g_unpack
      assign w_a[gi] = r_line[gi*LANE_W +: OPND_W];
      assign w_b[gi] = r_line[gi*LANE_W + OPND_W +: OPND_W];
    end

    // Adder k always works on lane cnt+k of the captured line.
    for (gi = 0; gi < LANES_PER_CYCLE; gi++) begin : g_adder
      logic [4:0] w_idx;
      assign w_idx = r_cnt[4:0] + 5'(gi);
      add_num_lane_adder u_adder (
        .i_a    (w_a[w_idx]),
        .i_b    (w_b[w_idx]),
        .o_lane (w_lane[gi]),
        .o_ovf  (w_ovf[gi])
      );
    end

    // Each result lane is loaded only in the COMPUTE step that covers it.
    for (gi = 0; gi < N_PAIRS; gi++) begin : g_wr
      localparam int         OFF  = gi % LANES_PER_CYCLE;
      localparam logic [5:0] BASE = 6'(gi - OFF);
      logic w_hit;
      assign w_hit = (r_state == COMPUTE) && (r_cnt == BASE);
      assign w_res_data_next[gi*LANE_W +: LANE_W] =
        w_hit ? w_lane[OFF] : r_res_data[gi*LANE_W +: LANE_W];
      assign w_res_ovf_next[gi] = w_hit ? w_ovf[OFF] : r_res_ovf[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_exp_mdata <= '0;
      r_line      <= '0;
      r_cnt       <= '0;
      r_res_data  <= '0;
      r_res_ovf   <= '0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_err_tag   <= 1'b0;
    end else begin
      r_res_data <= w_res_data_next;
      r_res_ovf  <= w_res_ovf_next;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_exp_mdata <= exp_mdata;
            r_err_tag   <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          if (rsp_valid) begin
            if (w_tag_match) begin
              r_line  <= rsp_data;
              r_cnt   <= '0;
              r_state <= COMPUTE;
            end else begin
              r_err_tag <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          r_cnt <= r_cnt + CNT_STEP;
          if (r_cnt == LAST_CNT) begin
            r_res_valid <= 1'b1;
            r_state     <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_ovf   = r_res_ovf;
  assign busy      = r_busy;
  assign err_tag   = r_err_tag;

endmodule

// File: tb/tb_add_num_operand_unpack.sv
// Self-checking bench: three unpack instances (4, 1 and 32 lanes per cycle)
// share stimulus and are checked against an arithmetic model of the pair sums.
module tb_add_num_operand_unpack;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   exp_mdata = '0;
  logic          rsp_valid = 1'b0;
  logic [15:0]   rsp_mdata = '0;
  logic [511:0]  rsp_data = '0;
  logic          res_ready = 1'b1;

  logic          res_valid_v [3];
  logic [511:0]  res_data_v  [3];
  logic [31:0]   res_ovf_v   [3];
  logic          busy_v      [3];
  logic          err_tag_v   [3];

  int            checks = 0;
  int            failures = 0;
  logic [511:0]  model_line = '0;
  logic          model_err = 1'b0;
  bit            cmp_en = 1'b0;
  int            lat [3];
  logic [511:0]  cap_data [3];
  logic [31:0]   cap_ovf  [3];

  always #5 clk = ~clk;

  add_num_operand_unpack #(.LANES_PER_CYCLE(4), .MDATA_W(16)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .exp_mdata(exp_mdata),
    .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
    .res_valid(res_valid_v[0]), .res_ready(res_ready), .res_data(res_data_v[0]),
    .res_ovf(res_ovf_v[0]), .busy(busy_v[0]), .err_tag(err_tag_v[0]));

  add_num_operand_unpack #(.LANES_PER_CYCLE(1), .MDATA_W(16)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .exp_mdata(exp_mdata),
    .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
    .res_valid(res_valid_v[1]), .res_ready(res_ready), .res_data(res_data_v[1]),
    .res_ovf(res_ovf_v[1]), .busy(busy_v[1]), .err_tag(err_tag_v[1]));

  add_num_operand_unpack #(.LANES_PER_CYCLE(32), .MDATA_W(16)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start), .exp_mdata(exp_mdata),
    .rsp_valid(rsp_valid), .rsp_mdata(rsp_mdata), .rsp_data(rsp_data),
    .res_valid(res_valid_v[2]), .res_ready(res_ready), .res_data(res_data_v[2]),
    .res_ovf(res_ovf_v[2]), .busy(busy_v[2]), .err_tag(err_tag_v[2]));

  // Cycles from the capturing edge to res_valid: 32 / lanes per cycle.
  function automatic int steps(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 32 : 1);
  endfunction

  function automatic logic [511:0] model_data(input logic [511:0] line);
    logic [511:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      s = int'(line[16*i +: 8]) + int'(line[16*i+8 +: 8]);
`ifdef ADD_NUM_UNPACK_SATURATE_EN
      if (s > 255) s = 255;
`endif
      r[16*i +: 16] = 16'(s);
    end
    return r;
  endfunction

  function automatic logic [31:0] model_ovf(input logic [511:0] line);
    logic [31:0] r;
    for (int i = 0; i < 32; i++)
      r[i] = (int'(line[16*i +: 8]) + int'(line[16*i+8 +: 8])) > 255;
    return r;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int j = 0; j < 16; j++) l[32*j +: 32] = $urandom;
    return l;
  endfunction

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        if (res_valid_v[i] === 1'b1) begin
          check($sformatf("res_data[%0d]", i), res_data_v[i], model_data(model_line));
          check($sformatf("res_ovf[%0d]", i), 512'(res_ovf_v[i]), 512'(model_ovf(model_line)));
        end
        check($sformatf("err_tag[%0d]", i), 512'(err_tag_v[i]), 512'(model_err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] tag);
    start = 1'b1;
    exp_mdata = tag;
    tick();
    start = 1'b0;
    model_err = 1'b0;
    check("busy_after_start", 512'(busy_v[0]), 512'(1));
  endtask

  task automatic send_rsp(input logic [15:0] tag, input logic [511:0] line, input bit match);
    rsp_valid = 1'b1;
    rsp_mdata = tag;
    rsp_data = line;
    tick();
    rsp_valid = 1'b0;
    if (match) model_line = line;
    else model_err = 1'b1;
  endtask

  task automatic wait_all_idle();
    int n;
    n = 0;
    while ((busy_v[0] | busy_v[1] | busy_v[2]) && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 400) begin
      failures++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
    res_ready = 1'b1;
  endtask

  // Measures res_valid latency of every instance with res_ready held high.
  task automatic run_latency(input logic [15:0] tag, input logic [511:0] line);
    res_ready = 1'b1;
    do_start(tag);
    send_rsp(tag, line, 1'b1);
    for (int i = 0; i < 3; i++) lat[i] = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      for (int i = 0; i < 3; i++) begin
        if (lat[i] < 0 && res_valid_v[i] === 1'b1) begin
          lat[i] = k;
          cap_data[i] = res_data_v[i];
          cap_ovf[i] = res_ovf_v[i];
        end
      end
    end
    for (int i = 0; i < 3; i++)
      check($sformatf("latency[%0d]", i), 512'(lat[i]), 512'(steps(i)));
    wait_all_idle();
  endtask

  initial begin
    logic [511:0] l;
    logic [511:0] exp_l;
    int n;
    bit seen;

    tick(); tick();
    check("rst_valid", 512'(res_valid_v[0]), 512'(0));
    check("rst_data", res_data_v[0], 512'(0));
    check("rst_ovf", 512'(res_ovf_v[0]), 512'(0));
    check("rst_busy", 512'(busy_v[0]), 512'(0));
    check("rst_err", 512'(err_tag_v[0]), 512'(0));
    reset_n = 1'b1;
    tick();
    cmp_en = 1'b1;

    // All pairs 3+4.
    for (int i = 0; i < 32; i++) l[16*i +: 16] = 16'h0403;
    run_latency(16'h00A5, l);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 32; j++) exp_l[16*j +: 16] = 16'h0007;
      check($sformatf("t1_data[%0d]", i), cap_data[i], exp_l);
      check($sformatf("t1_ovf[%0d]", i), 512'(cap_ovf[i]), 512'(0));
    end

    // Boundary pairs: (200,100) and (255,255).
    l = '0;
    l[15:0] = {8'd100, 8'd200};
    l[511:496] = {8'd255, 8'd255};
    run_latency(16'h1234, l);
    for (int i = 0; i < 3; i++) begin
`ifdef ADD_NUM_UNPACK_SATURATE_EN
      check($sformatf("t2_lane0[%0d]", i), 512'(cap_data[i][15:0]), 512'(255));
      check($sformatf("t2_lane31[%0d]", i), 512'(cap_data[i][511:496]), 512'(255));
`else
      check($sformatf("t2_lane0[%0d]", i), 512'(cap_data[i][15:0]), 512'(300));
      check($sformatf("t2_lane31[%0d]", i), 512'(cap_data[i][511:496]), 512'(510));
`endif
      check($sformatf("t2_ovf[%0d]", i), 512'(cap_ovf[i]), 512'(32'h8000_0001));
    end

    // Wrong tag, then the right one.
    do_start(16'h0002);
    send_rsp(16'h0001, rand_line(), 1'b0);
    check("err_set", 512'(err_tag_v[0]), 512'(1));
    check("err_still_waiting", 512'(busy_v[0]), 512'(1));
    tick();
    send_rsp(16'h0002, rand_line(), 1'b1);
    wait_all_idle();
    check("err_sticky", 512'(err_tag_v[0]), 512'(1));
    do_start(16'h0003);
    check("err_cleared", 512'(err_tag_v[0]), 512'(0));
    send_rsp(16'h0003, rand_line(), 1'b1);
    wait_all_idle();

    // Back-pressure with ignored pulses in OUTPUT.
    res_ready = 1'b0;
    do_start(16'h0055);
    send_rsp(16'h0055, rand_line(), 1'b1);
    n = 0;
    while (res_valid_v[0] !== 1'b1 && n < 20) begin tick(); n++; end
    check("stall_valid_seen", 512'(res_valid_v[0]), 512'(1));
    for (int c = 0; c < 5; c++) begin
      if (c == 1) begin start = 1'b1; exp_mdata = 16'h0066; end
      if (c == 3) begin rsp_valid = 1'b1; rsp_mdata = 16'h0055; rsp_data = rand_line(); end
      tick();
      start = 1'b0;
      rsp_valid = 1'b0;
      check("stall_valid_hold", 512'(res_valid_v[0]), 512'(1));
      check("stall_busy_hold", 512'(busy_v[0]), 512'(1));
    end
    res_ready = 1'b1;
    tick();
    check("hs_valid_drop", 512'(res_valid_v[0]), 512'(0));
    check("hs_busy_drop", 512'(busy_v[0]), 512'(0));
    tick();
    check("hs_stays_idle", 512'(busy_v[0]), 512'(0));
    wait_all_idle();

    // start and a matching response in the same IDLE cycle: response dropped.
    start = 1'b1; exp_mdata = 16'h0055;
    rsp_valid = 1'b1; rsp_mdata = 16'h0055; rsp_data = rand_line();
    tick();
    start = 1'b0; rsp_valid = 1'b0; model_err = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (res_valid_v[0] | res_valid_v[1] | res_valid_v[2]) seen = 1'b1;
    end
    check("same_cycle_rsp_dropped", 512'(seen), 512'(0));
    check("same_cycle_still_busy", 512'(busy_v[0]), 512'(1));
    send_rsp(16'h0055, rand_line(), 1'b1);
    wait_all_idle();

    // Asynchronous reset during COMPUTE.
    do_start(16'h0777);
    send_rsp(16'h0777, rand_line(), 1'b1);
    tick(); tick(); tick();
    reset_n = 1'b0;
    model_err = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mid_rst_valid[%0d]", i), 512'(res_valid_v[i]), 512'(0));
      check($sformatf("mid_rst_data[%0d]", i), res_data_v[i], 512'(0));
      check($sformatf("mid_rst_ovf[%0d]", i), 512'(res_ovf_v[i]), 512'(0));
      check($sformatf("mid_rst_busy[%0d]", i), 512'(busy_v[i]), 512'(0));
    end
    reset_n = 1'b1;
    tick();
    l = rand_line();
    run_latency(16'h0778, l);
    check("post_rst_data", cap_data[0], model_data(l));

    // Randomized runs with random tag errors and random back-pressure.
    for (int r = 0; r < 10; r++) begin
      logic [15:0] tag;
      tag = 16'($urandom);
      do_start(tag);
      if ($urandom_range(0, 2) == 0) send_rsp(tag ^ 16'h0100, rand_line(), 1'b0);
      send_rsp(tag, rand_line(), 1'b1);
      n = 0;
      while ((busy_v[0] | busy_v[1] | busy_v[2]) && n < 400) begin
        res_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      wait_all_idle();
    end

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_num_operand_unpack.md
# add_num_operand_unpack

Downstream stage of the add-two-numbers AFU read path. It captures the CCI-P c0 memory-read response line matching an expected mdata tag and unpacks 32 operand pairs of 8 bits each. It adds the pairs over a configurable number of cycles and presents one packed result line, plus a per-pair overflow mask, to the write stage over a valid/ready handshake.

## Interface

Clock/reset: one clock; reset is asynchronous and active-low (`clk`, `reset_n`).

Parameters:
- `LANES_PER_CYCLE`, default 4: pairs summed per COMPUTE cycle. Legal values: 1, 2, 4, 8, 16, 32.
- `MDATA_W`, default 16: width of the response tag.

Ports:
- `clk`  in  1  AFU clock (host_ccip clk)
- `reset_n`  in  1  asynchronous active-low reset
- `start`  in  1  arm for one response; accepted only in IDLE
- `exp_mdata`  in  MDATA_W  tag to match; sampled with `start`
- `rsp_valid`  in  1  c0 read response valid (rspValid)
- `rsp_mdata`  in  MDATA_W  c0 response header mdata
- `rsp_data`  in  512  c0 response line
- `res_valid`  out  1  result line available
- `res_ready`  in  1  write stage accepts result
- `res_data`  out  512  packed sums
- `res_ovf`  out  32  bit i set when a_i + b_i > 255
- `busy`  out  1  high in any state other than IDLE
- `err_tag`  out  1  sticky: a response arrived in WAIT_RSP with a wrong tag

## Operation

- Pair i (0..31):
  - a_i = rsp_data[16i+7:16i]
  - b_i = rsp_data[16i+15:16i+8]
- Result lane i = res_data[16i+15:16i]. The value depends on the configuration (see below).
- States:
  - IDLE: on `start`, latch `exp_mdata`, clear `err_tag`, go to WAIT_RSP.
  - WAIT_RSP: on `rsp_valid` with `rsp_mdata == exp_mdata` latched, capture `rsp_data`, clear the lane counter, go to COMPUTE. On a mismatched tag, set `err_tag` and stay in WAIT_RSP.
  - COMPUTE: sum lanes [cnt, cnt+LANES_PER_CYCLE-1] and advance cnt by LANES_PER_CYCLE. When cnt reaches 32, go to OUTPUT.
  - OUTPUT: `res_valid`=1. `res_data`/`res_ovf` are held stable until `res_ready`. On `res_valid && res_ready`, go to IDLE.
- Ignored inputs:
  - `start` outside IDLE.
  - `rsp_valid` outside WAIT_RSP, including while in OUTPUT.
- `start` and a matching `rsp_valid` in the same IDLE cycle: only `start` is taken; the response is dropped.
- Reset values: state IDLE; `res_valid` 0; `res_data` 0; `res_ovf` 0; `busy` 0; `err_tag` 0; lane counter 0.
- Reset asserted mid-operation: return immediately to IDLE. The captured line and any partial sums are discarded.

## Timing

- Every output is registered.
- `start` in cycle T → `busy` goes high in T+1.
- A matching response in cycle R:
  - COMPUTE runs from R+1 to R+32/LANES_PER_CYCLE.
  - `res_valid` rises at R+32/LANES_PER_CYCLE+1.
  - With the default parameter, `res_valid` rises at R+9.
- `res_ready` held high during OUTPUT → IDLE on the next cycle. `busy` drops in the same cycle `res_valid` drops.
- Back-to-back: `start` is accepted one cycle after the handshake completes.
- `err_tag` is visible the cycle after the mismatched response.

## Configuration

- Macro `ADD_NUM_UNPACK_SATURATE_EN`.
- Defined: lane i = {8'h00, sat8(a_i + b_i)}, i.e. the sum clamped to 255.
- Undefined: lane i = {7'h00, a_i + b_i}, the full 9-bit sum.
- `res_ovf` is produced identically in both cases.

## Structure

- Package `add_num_pkg` holds:
  - `N_PAIRS` = 32, `OPND_W` = 8, `LANE_W` = 16;
  - typedefs `t_opnd` and `t_lane`;
  - the enum `t_unpack_state` (IDLE, WAIT_RSP, COMPUTE, OUTPUT).
- One sub-module, `add_num_lane_adder`:
  - combinational;
  - takes a_i and b_i;
  - returns the lane value and the ovf bit, with the saturation macro honoured inside it.
- The top module instantiates LANES_PER_CYCLE adders and muxes the capture register by cnt.

## Test plan

- Default parameters, all pairs a=3, b=4, matching tag 16'h00A5:
  - every lane = 16'h0007;
  - `res_ovf` = 0;
  - `res_valid` at R+9.
- Pair 0 = (200, 100), pair 31 = (255, 255):
  - lane 0 = 300 (or 255 under the macro), lane 31 = 510 (or 255 under the macro);
  - `res_ovf` = 32'h8000_0001.
- In WAIT_RSP, response with tag 16'h0001 while expecting 16'h0002, followed by a correct-tag response: `err_tag`=1 while the wrong line is ignored, the result comes from the second line, and the next `start` clears `err_tag`.
- `res_ready` held low 5 cycles in OUTPUT while extra `rsp_valid`/`start` pulses arrive:
  - outputs stay stable;
  - the pulses are ignored;
  - one handshake, then IDLE.
- `reset_n` pulsed low during COMPUTE: all outputs are 0 the next cycle; a fresh `start` plus response then produces the correct result.
- LANES_PER_CYCLE=1 and 32: `res_valid` at R+33 and R+2 respectively, with identical `res_data`.
